// File: rtl/motor_pwm_driver.sv
// Two-wheel PWM driver: decodes the drive-mode code into per-wheel duty/direction
// targets and ramps each wheel toward them once per PWM period, with a zero-duty dead-band before reversing.
module motor_pwm_driver #(
  parameter int PWM_PERIOD   = 1000,
  parameter int CNT_W        = 10,
  parameter int RAMP_STEP    = 100,
  parameter int DEAD_PERIODS = 2,
  parameter int DUTY_SLOW    = 300,
  parameter int DUTY_MEDIUM  = 600,
  parameter int DUTY_FAST    = 900,
  parameter int DUTY_TURN    = 500
) (
  input  logic             clk_50,
  input  logic             reset,
  input  logic [3:0]       drive_state,
  output logic             pwm_left,
  output logic             pwm_right,
  output logic             dir_left,
  output logic             dir_right,
  output logic [CNT_W-1:0] duty_left,
  output logic [CNT_W-1:0] duty_right,
  output logic             settled
);

  localparam int DW = (DEAD_PERIODS < 2) ? 1 : $clog2(DEAD_PERIODS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PWM_PERIOD - 1);
  localparam logic [CNT_W-1:0] D_SLOW    = CNT_W'(DUTY_SLOW);
  localparam logic [CNT_W-1:0] D_MEDIUM  = CNT_W'(DUTY_MEDIUM);
  localparam logic [CNT_W-1:0] D_FAST    = CNT_W'(DUTY_FAST);
  localparam logic [CNT_W-1:0] D_TURN    = CNT_W'(DUTY_TURN);
  localparam logic [CNT_W:0]   STEP_W    = (CNT_W + 1)'(RAMP_STEP);
  localparam logic [DW-1:0]    DEAD_LOAD = DW'(DEAD_PERIODS);

  typedef enum logic [1:0] {
    TRACK     = 2'd0,
    RAMP_DOWN = 2'd1,
    DEADBAND  = 2'd2
  } side_st_e;

  // Index 0 is the left wheel, index 1 the right wheel.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       ds_q;
  logic             wrap;
  side_st_e         st_q   [2];
  side_st_e         st_d   [2];
  logic [CNT_W-1:0] duty_q [2];
  logic [CNT_W-1:0] duty_d [2];
  logic [DW-1:0]    dead_q [2];
  logic [DW-1:0]    dead_d [2];
  logic [1:0]       dir_q, dir_d;
  logic [1:0]       pwm_q, pwm_d;
  logic [1:0]       mism;
  logic             settled_q, settled_d;
  logic [1:0][CNT_W-1:0] tgt_duty;
  logic [1:0]            tgt_dir;

  // Saturating one-step move of cur toward tgt; never overshoots, never wraps.
  function automatic logic [CNT_W-1:0] ramp_to(input logic [CNT_W-1:0] cur,
                                               input logic [CNT_W-1:0] tgt);
    logic [CNT_W:0] cur_w, tgt_w, sum_w;
    cur_w = {1'b0, cur};
    tgt_w = {1'b0, tgt};
    sum_w = cur_w + STEP_W;
    if (cur_w < tgt_w)
      ramp_to = (sum_w >= tgt_w) ? tgt : sum_w[CNT_W-1:0];
    else if (cur_w > tgt_w)
      ramp_to = ((cur_w - tgt_w) <= STEP_W) ? tgt : CNT_W'(cur_w - STEP_W);
    else
      ramp_to = cur;
  endfunction

  always_comb begin
    tgt_duty = '0;
    tgt_dir  = 2'b11;
    case (ds_q)
      4'd1:  tgt_duty[1] = D_TURN;
      4'd2:  tgt_duty[0] = D_TURN;
      4'd3:  tgt_duty = {D_SLOW, D_SLOW};
      4'd4:  tgt_duty = {D_MEDIUM, D_MEDIUM};
      4'd5:  tgt_duty = {D_FAST, D_FAST};
      4'd6: begin
        tgt_duty = {D_SLOW, D_SLOW};
        tgt_dir  = 2'b00;
      end
      4'd7: begin
        tgt_duty[1] = D_TURN;
        tgt_dir[1]  = 1'b0;
      end
      4'd8: begin
        tgt_duty[0] = D_TURN;
        tgt_dir[0]  = 1'b0;
      end
      4'd9: begin
        tgt_duty   = {D_TURN, D_TURN};
        tgt_dir[0] = 1'b0;
      end
      4'd10: begin
        tgt_duty   = {D_TURN, D_TURN};
        tgt_dir[1] = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    wrap      = (cnt_q == CNT_LAST);
    cnt_d     = wrap ? '0 : cnt_q + 1'b1;
    dir_d     = dir_q;
    settled_d = 1'b1;
    for (int s = 0; s < 2; s++) begin
      st_d[s]   = st_q[s];
      duty_d[s] = duty_q[s];
      dead_d[s] = dead_q[s];
      mism[s]   = (tgt_duty[s] != '0) && (tgt_dir[s] != dir_q[s]);
      pwm_d[s]  = (cnt_q < duty_q[s]);
      if (wrap) begin
        case (st_q[s])
          TRACK: begin
            if (mism[s] && duty_q[s] != '0) begin
              st_d[s] = RAMP_DOWN;
            end else if (mism[s]) begin
              st_d[s]   = DEADBAND;
              dead_d[s] = DEAD_LOAD;
            end else begin
              duty_d[s] = ramp_to(duty_q[s], tgt_duty[s]);
            end
          end
          RAMP_DOWN: begin
            if (!mism[s]) begin
              st_d[s]   = TRACK;
              duty_d[s] = ramp_to(duty_q[s], tgt_duty[s]);
            end else begin
              duty_d[s] = ramp_to(duty_q[s], '0);
              if (ramp_to(duty_q[s], '0) == '0) begin
                st_d[s]   = DEADBAND;
                dead_d[s] = DEAD_LOAD;
              end
            end
          end
          DEADBAND: begin
            // The dead-band always runs to completion; direction is only taken at its last wrap.
            dead_d[s] = dead_q[s] - 1'b1;
            if (dead_q[s] == DW'(1)) begin
              st_d[s] = TRACK;
              if (tgt_duty[s] != '0) dir_d[s] = tgt_dir[s];
            end
          end
          default: st_d[s] = TRACK;
        endcase
      end
      if (st_q[s] != TRACK || duty_q[s] != tgt_duty[s] || mism[s]) settled_d = 1'b0;
    end
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      ds_q      <= 4'd0;
      dir_q     <= 2'b11;
      pwm_q     <= 2'b00;
      settled_q <= 1'b1;
      for (int s = 0; s < 2; s++) begin
        st_q[s]   <= TRACK;
        duty_q[s] <= '0;
        dead_q[s] <= '0;
      end
    end else begin
      cnt_q     <= cnt_d;
      ds_q      <= drive_state;
      dir_q     <= dir_d;
      pwm_q     <= pwm_d;
      settled_q <= settled_d;
      for (int s = 0; s < 2; s++) begin
        st_q[s]   <= st_d[s];
        duty_q[s] <= duty_d[s];
        dead_q[s] <= dead_d[s];
      end
    end
  end

  assign pwm_left   = pwm_q[0];
  assign pwm_right  = pwm_q[1];
  assign dir_left   = dir_q[0];
  assign dir_right  = dir_q[1];
  assign duty_left  = duty_q[0];
  assign duty_right = duty_q[1];
  assign settled    = settled_q;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Directed bench for motor_pwm_driver: per-scenario tasks with hand-computed duty/direction sequences.
module tb_motor_pwm_driver;

  localparam int PERIOD = 1000;

  logic       clk;
  logic       rst;
  logic [3:0] drive_state;
  logic       pwm_left, pwm_right, dir_left, dir_right, settled;
  logic [9:0] duty_left, duty_right;

  int n_checks = 0;
  int n_fail   = 0;
  int tb_cnt;

  motor_pwm_driver dut (
    .clk_50      (clk),
    .reset       (rst),
    .drive_state (drive_state),
    .pwm_left    (pwm_left),
    .pwm_right   (pwm_right),
    .dir_left    (dir_left),
    .dir_right   (dir_right),
    .duty_left   (duty_left),
    .duty_right  (duty_right),
    .settled     (settled)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Bench-side period counter, used only to know where wrap edges fall.
  always @(posedge clk or posedge rst) begin
    if (rst) tb_cnt <= 0;
    else     tb_cnt <= (tb_cnt == PERIOD - 1) ? 0 : tb_cnt + 1;
  end

  task automatic wait_wrap();
    @(negedge clk);
    while (tb_cnt != PERIOD - 1) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic [3:0] code);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    drive_state = code;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_state = 4'b0101;
    repeat (4) @(negedge clk);
    n_checks++; if (duty_left !== 10'd0)  begin n_fail++; $display("FAIL reset_duty_left: got %0d expected 0", duty_left); end
    n_checks++; if (duty_right !== 10'd0) begin n_fail++; $display("FAIL reset_duty_right: got %0d expected 0", duty_right); end
    n_checks++; if ({dir_left, dir_right} !== 2'b11) begin n_fail++; $display("FAIL reset_dir: got %b expected 11", {dir_left, dir_right}); end
    n_checks++; if ({pwm_left, pwm_right} !== 2'b00) begin n_fail++; $display("FAIL reset_pwm: got %b expected 00", {pwm_left, pwm_right}); end
    n_checks++; if (settled !== 1'b1) begin n_fail++; $display("FAIL reset_settled: got %b expected 1", settled); end
    rst = 1'b0;
  endtask

  task automatic test_fast_ramp();
    int highs_l, highs_r;
    for (int k = 1; k <= 9; k++) begin
      wait_wrap();
      n_checks++; if (duty_left !== 10'(100 * k))  begin n_fail++; $display("FAIL fast_duty_left w%0d: got %0d expected %0d", k, duty_left, 100 * k); end
      n_checks++; if (duty_right !== 10'(100 * k)) begin n_fail++; $display("FAIL fast_duty_right w%0d: got %0d expected %0d", k, duty_right, 100 * k); end
      n_checks++; if (settled !== 1'b0) begin n_fail++; $display("FAIL fast_settled_early w%0d: got %b expected 0", k, settled); end
    end
    @(posedge clk); #1;
    n_checks++; if (settled !== 1'b1) begin n_fail++; $display("FAIL fast_settled: got %b expected 1", settled); end
    highs_l = 0;
    highs_r = 0;
    repeat (PERIOD) begin
      @(negedge clk);
      if (pwm_left)  highs_l++;
      if (pwm_right) highs_r++;
    end
    n_checks++; if (highs_l != 900) begin n_fail++; $display("FAIL fast_pwm_left_highs: got %0d expected 900", highs_l); end
    n_checks++; if (highs_r != 900) begin n_fail++; $display("FAIL fast_pwm_right_highs: got %0d expected 900", highs_r); end
  endtask

  task automatic test_ramp_abort();
    int exp_d [8] = '{900, 800, 700, 600, 500, 400, 300, 300};
    drive_state = 4'b0110;
    for (int k = 0; k < 8; k++) begin
      wait_wrap();
      n_checks++; if (duty_left !== 10'(exp_d[k]))  begin n_fail++; $display("FAIL abort_duty_left w%0d: got %0d expected %0d", k + 1, duty_left, exp_d[k]); end
      n_checks++; if (duty_right !== 10'(exp_d[k])) begin n_fail++; $display("FAIL abort_duty_right w%0d: got %0d expected %0d", k + 1, duty_right, exp_d[k]); end
      n_checks++; if ({dir_left, dir_right} !== 2'b11) begin n_fail++; $display("FAIL abort_dir w%0d: got %b expected 11", k + 1, {dir_left, dir_right}); end
      if (k == 4) drive_state = 4'b0011;
    end
    @(posedge clk); #1;
    n_checks++; if (settled !== 1'b1) begin n_fail++; $display("FAIL abort_settled: got %b expected 1", settled); end
  endtask

  task automatic test_reverse();
    int exp_d [15] = '{900, 800, 700, 600, 500, 400, 300, 200, 100, 0, 0, 0, 100, 200, 300};
    drive_state = 4'b0101;
    for (int k = 4; k <= 9; k++) begin
      wait_wrap();
      n_checks++; if (duty_left !== 10'(100 * k)) begin n_fail++; $display("FAIL refast_duty_left: got %0d expected %0d", duty_left, 100 * k); end
    end
    @(posedge clk); #1;
    n_checks++; if (settled !== 1'b1) begin n_fail++; $display("FAIL refast_settled: got %b expected 1", settled); end
    drive_state = 4'b0110;
    for (int k = 0; k < 15; k++) begin
      logic exp_dir;
      exp_dir = (k < 11) ? 1'b1 : 1'b0;
      wait_wrap();
      n_checks++; if (duty_left !== 10'(exp_d[k]))  begin n_fail++; $display("FAIL rev_duty_left w%0d: got %0d expected %0d", k + 1, duty_left, exp_d[k]); end
      n_checks++; if (duty_right !== 10'(exp_d[k])) begin n_fail++; $display("FAIL rev_duty_right w%0d: got %0d expected %0d", k + 1, duty_right, exp_d[k]); end
      n_checks++; if (dir_left !== exp_dir)  begin n_fail++; $display("FAIL rev_dir_left w%0d: got %b expected %b", k + 1, dir_left, exp_dir); end
      n_checks++; if (dir_right !== exp_dir) begin n_fail++; $display("FAIL rev_dir_right w%0d: got %b expected %b", k + 1, dir_right, exp_dir); end
      n_checks++; if (settled !== 1'b0) begin n_fail++; $display("FAIL rev_settled_early w%0d: got %b expected 0", k + 1, settled); end
    end
    @(posedge clk); #1;
    n_checks++; if (settled !== 1'b1) begin n_fail++; $display("FAIL rev_settled: got %b expected 1", settled); end
  endtask

  task automatic test_hard_l();
    int   exp_l  [8] = '{0, 0, 0, 100, 200, 300, 400, 500};
    int   exp_r  [8] = '{100, 200, 300, 400, 500, 500, 500, 500};
    logic exp_dl [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    apply_reset(4'b1001);
    for (int k = 0; k < 8; k++) begin
      wait_wrap();
      n_checks++; if (duty_left !== 10'(exp_l[k]))  begin n_fail++; $display("FAIL hardl_duty_left w%0d: got %0d expected %0d", k + 1, duty_left, exp_l[k]); end
      n_checks++; if (duty_right !== 10'(exp_r[k])) begin n_fail++; $display("FAIL hardl_duty_right w%0d: got %0d expected %0d", k + 1, duty_right, exp_r[k]); end
      n_checks++; if (dir_left !== exp_dl[k]) begin n_fail++; $display("FAIL hardl_dir_left w%0d: got %b expected %b", k + 1, dir_left, exp_dl[k]); end
      n_checks++; if (dir_right !== 1'b1) begin n_fail++; $display("FAIL hardl_dir_right w%0d: got %b expected 1", k + 1, dir_right); end
      n_checks++; if (settled !== 1'b0) begin n_fail++; $display("FAIL hardl_settled_early w%0d: got %b expected 0", k + 1, settled); end
    end
    @(posedge clk); #1;
    n_checks++; if (settled !== 1'b1) begin n_fail++; $display("FAIL hardl_settled: got %b expected 1", settled); end
  endtask

  task automatic test_async_reset();
    apply_reset(4'b0101);
    repeat (4) wait_wrap();
    n_checks++; if (duty_left !== 10'd400) begin n_fail++; $display("FAIL areset_pre_duty: got %0d expected 400", duty_left); end
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (pwm_left !== 1'b1) begin n_fail++; $display("FAIL areset_pre_pwm: got %b expected 1", pwm_left); end
    #4 rst = 1'b1;
    #1;
    n_checks++; if ({pwm_left, pwm_right} !== 2'b00) begin n_fail++; $display("FAIL areset_pwm: got %b expected 00", {pwm_left, pwm_right}); end
    n_checks++; if (duty_left !== 10'd0 || duty_right !== 10'd0) begin n_fail++; $display("FAIL areset_duty: got %0d/%0d expected 0/0", duty_left, duty_right); end
    n_checks++; if ({dir_left, dir_right} !== 2'b11) begin n_fail++; $display("FAIL areset_dir: got %b expected 11", {dir_left, dir_right}); end
    @(negedge clk);
    rst = 1'b0;
    wait_wrap();
    n_checks++; if (duty_left !== 10'd100 || duty_right !== 10'd100) begin n_fail++; $display("FAIL areset_restart: got %0d/%0d expected 100/100", duty_left, duty_right); end
  endtask

  task automatic test_invalid_code();
    apply_reset(4'b0100);
    repeat (6) wait_wrap();
    @(posedge clk); #1;
    n_checks++; if (duty_left !== 10'd600 || settled !== 1'b1) begin n_fail++; $display("FAIL inv_medium: got duty %0d settled %b expected 600/1", duty_left, settled); end
    drive_state = 4'b1111;
    for (int k = 1; k <= 6; k++) begin
      wait_wrap();
      n_checks++; if (duty_left !== 10'(600 - 100 * k))  begin n_fail++; $display("FAIL inv_duty_left w%0d: got %0d expected %0d", k, duty_left, 600 - 100 * k); end
      n_checks++; if (duty_right !== 10'(600 - 100 * k)) begin n_fail++; $display("FAIL inv_duty_right w%0d: got %0d expected %0d", k, duty_right, 600 - 100 * k); end
      n_checks++; if ({dir_left, dir_right} !== 2'b11) begin n_fail++; $display("FAIL inv_dir w%0d: got %b expected 11", k, {dir_left, dir_right}); end
    end
    @(posedge clk); #1;
    n_checks++; if (settled !== 1'b1) begin n_fail++; $display("FAIL inv_settled: got %b expected 1", settled); end
    n_checks++; if ({pwm_left, pwm_right} !== 2'b00) begin n_fail++; $display("FAIL inv_pwm_zero: got %b expected 00", {pwm_left, pwm_right}); end
  endtask

  initial begin
    rst = 1'b1;
    drive_state = 4'b0000;
    test_reset();
    test_fast_ramp();
    test_ramp_abort();
    test_reverse();
    test_hard_l();
    test_async_reset();
    test_invalid_code();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
